// File: rtl/nios2_system_v0_cpu_debug_jtag_host_if.sv
// Command/response handshake bundle for the debug JTAG host driver.
// master: test master issuing commands and consuming responses; slave: the host driver.
// Signals: cmd_valid/cmd_ready/cmd_ir/cmd_data in, rsp_valid/rsp_ready/rsp_data out.
interface nios2_system_v0_cpu_debug_jtag_host_if #(
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios2_system_v0_cpu_debug_jtag_host.sv
// Host-side virtual-JTAG driver: runs UIR/CDR/SDR/UDR for one command word, returns TDO capture.
// Latency: (DR_WIDTH+3)*2*HALF_CYCLES+1 clk from accept to rsp_valid (165 with defaults).
// Backpressure: one command in flight; cmd_ready low until the response is taken (rsp_ready).
//
// Ports: clk, reset_n (async active-low); bus (slave modport: cmd_* in, rsp_* out);
//        tck/tdi/tdo serial link, ir_in, vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti strobes.
// Optional: define DEBUG_HOST_SKIP_IR_EN to skip UIR when the IR is unchanged since the last load.
module nios2_system_v0_cpu_debug_jtag_host #(
    parameter int HALF_CYCLES = 2,
    parameter int DR_WIDTH    = 38
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    nios2_system_v0_cpu_debug_jtag_host_if.slave  bus,
    output logic                                  tck,
    output logic                                  tdi,
    input  logic                                  tdo,
    output logic [1:0]                            ir_in,
    output logic                                  vs_uir,
    output logic                                  vs_cdr,
    output logic                                  vs_sdr,
    output logic                                  vs_udr,
    output logic                                  jtag_state_rti
);
    localparam int              SLOT_CYCLES = 2 * HALF_CYCLES;
    localparam int              SW          = $clog2(SLOT_CYCLES);
    localparam logic [SW-1:0]   SLOT_LAST   = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0]   SLOT_RISE   = SW'(HALF_CYCLES - 1);
    localparam logic [5:0]      BIT_LAST    = 6'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SHIFT,
        S_UDR,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [SW-1:0]       slot_q;
    logic [5:0]          bit_q;
    logic [DR_WIDTH-1:0] sr_q;
    logic [DR_WIDTH-1:0] sr_d;
    logic                tdo_smp_q;
    logic [1:0]          ir_q;
    logic                tck_q;
    logic                tdi_q;
    logic                uir_q;
    logic                cdr_q;
    logic                sdr_q;
    logic                udr_q;
    logic                rti_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                slot_end;
    logic                slot_rise;
    logic                skip_ir;

    // slot_rise is the edge that raises TCK; slot_end is the edge that drops it.
    assign slot_end  = (slot_q == SLOT_LAST);
    assign slot_rise = (slot_q == SLOT_RISE);

    // TDO bit sampled on the TCK rise enters at the top; the LSB has already been driven out.
    assign sr_d = {tdo_smp_q, sr_q[DR_WIDTH-1:1]};

`ifdef DEBUG_HOST_SKIP_IR_EN
    logic ir_valid_q;
    assign skip_ir = ir_valid_q && (bus.cmd_ir == ir_q);
`else
    assign skip_ir = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            tdo_smp_q   <= 1'b0;
            ir_q        <= 2'b00;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef DEBUG_HOST_SKIP_IR_EN
            ir_valid_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        ir_q        <= bus.cmd_ir;
                        sr_q        <= bus.cmd_data;
                        slot_q      <= '0;
                        bit_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        rti_q       <= 1'b0;
                        if (skip_ir) begin
                            state_q <= S_CDR;
                            cdr_q   <= 1'b1;
                        end else begin
                            state_q <= S_UIR;
                            uir_q   <= 1'b1;
                        end
                    end
                end

                S_UIR, S_CDR, S_SHIFT, S_UDR: begin
                    if (slot_rise) begin
                        tck_q <= 1'b1;
                        if (state_q == S_SHIFT) begin
                            tdo_smp_q <= tdo;
                        end
                    end
                    if (slot_end) begin
                        slot_q <= '0;
                        tck_q  <= 1'b0;
                        case (state_q)
                            S_UIR: begin
                                state_q <= S_CDR;
                                uir_q   <= 1'b0;
                                cdr_q   <= 1'b1;
`ifdef DEBUG_HOST_SKIP_IR_EN
                                ir_valid_q <= 1'b1;
`endif
                            end
                            S_CDR: begin
                                state_q <= S_SHIFT;
                                cdr_q   <= 1'b0;
                                sdr_q   <= 1'b1;
                                // First payload bit is set up while TCK is still low.
                                tdi_q   <= sr_q[0];
                            end
                            S_SHIFT: begin
                                sr_q <= sr_d;
                                if (bit_q == BIT_LAST) begin
                                    state_q <= S_UDR;
                                    sdr_q   <= 1'b0;
                                    udr_q   <= 1'b1;
                                    tdi_q   <= 1'b0;
                                end else begin
                                    bit_q <= bit_q + 6'd1;
                                    tdi_q <= sr_d[0];
                                end
                            end
                            default: begin
                                state_q     <= S_RESP;
                                udr_q       <= 1'b0;
                                rsp_valid_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        rti_q       <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = sr_q;
    assign tck            = tck_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_q;
    assign vs_uir         = uir_q;
    assign vs_cdr         = cdr_q;
    assign vs_sdr         = sdr_q;
    assign vs_udr         = udr_q;
    assign jtag_state_rti = rti_q;
endmodule

// File: tb/tb_nios2_system_v0_cpu_debug_jtag_host.sv
// Scoreboard bench for the debug JTAG host driver.
// Stimulus pushes expected responses; a negedge monitor pops and compares on each handshake.
// Also tracks strobe lengths, latency, TDI setup and response hold stability.
module tb_nios2_system_v0_cpu_debug_jtag_host;
    localparam int DW = 38;

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
        int            uir;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic tck, tdi, tdo;
    logic [1:0] ir_in;
    logic vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    nios2_system_v0_cpu_debug_jtag_host_if #(.DR_WIDTH(DW)) bus_if ();

    nios2_system_v0_cpu_debug_jtag_host #(.HALF_CYCLES(2), .DR_WIDTH(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus_if.slave),
        .tck            (tck),
        .tdi            (tdi),
        .tdo            (tdo),
        .ir_in          (ir_in),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .vs_udr         (vs_udr),
        .jtag_state_rti (jtag_state_rti)
    );

    always #5 clk = ~clk;

    // tdo source: 0 = loopback from tdi, 1 = shifting slave model, 2 = constant 1
    int            mode = 2;
    logic [DW-1:0] model_init = '0;
    logic [DW-1:0] model = '0;
    assign tdo = (mode == 0) ? tdi : (mode == 1) ? model[0] : 1'b1;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0, lat = 0;
    int   n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
    int   onehot_bad = 0, tdi_bad = 0, hold_bad = 0, rsp_seen_cnt = 0;
    logic active = 1'b0, seen = 1'b0;
    logic prev_tck = 1'b0, prev_tdi = 1'b0, prev_sdr = 1'b0;
    logic [DW-1:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            active = 1'b0;
            seen   = 1'b0;
        end else begin
            if (active) cyc++;
            if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}) > 1) onehot_bad++;
            if (!vs_sdr && tdi) tdi_bad++;
            if (tck && !prev_tck && (tdi !== prev_tdi)) tdi_bad++;
            if (vs_uir) n_uir++;
            if (vs_cdr) n_cdr++;
            if (vs_sdr) n_sdr++;
            if (vs_udr) n_udr++;
            // slave model shifts on each TCK fall that closes an SDR slot
            if (prev_tck && !tck && prev_sdr) model = model >> 1;
            if (bus_if.rsp_valid) begin
                rsp_seen_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    lat  = cyc;
                    held = bus_if.rsp_data;
                end else if (bus_if.rsp_data !== held) begin
                    hold_bad++;
                end
                if (bus_if.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", 64'(bus_if.rsp_data), 64'(e.data));
                        chk("latency", 64'(lat), 64'(e.lat));
                        chk("uir_clk", 64'(n_uir), 64'(e.uir));
                        chk("cdr_clk", 64'(n_cdr), 64'd4);
                        chk("sdr_clk", 64'(n_sdr), 64'd152);
                        chk("udr_clk", 64'(n_udr), 64'd4);
                    end
                    active = 1'b0;
                    seen   = 1'b0;
                end
            end
            if (bus_if.cmd_valid && bus_if.cmd_ready) begin
                active = 1'b1;
                cyc    = 0;
                n_uir  = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
                seen   = 1'b0;
                model  = model_init;
            end
        end
        prev_tck = tck;
        prev_tdi = tdi;
        prev_sdr = vs_sdr;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] ir, input logic [DW-1:0] data,
                        input logic [DW-1:0] exp_data, input int exp_lat, input int exp_uir);
        exp_t e;
        int   n;
        e.data = exp_data; e.lat = exp_lat; e.uir = exp_uir;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_ir    = ir;
        bus_if.cmd_data  = data;
        n = 0;
        @(negedge clk);
        while (!bus_if.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("cmd_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
    endtask

    task automatic wait_sig(input string nm, input int which);
        int n;
        n = 0;
        while (((which == 0) ? bus_if.rsp_valid : vs_sdr) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk(nm, 64'd0, 64'd1);
    endtask

    int bp_bad;
    int rv_after;

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_ir    = 2'b00;
        bus_if.cmd_data  = '0;
        bus_if.rsp_ready = 1'b1;

        // Reset state, tdo held high
        #2 reset_n = 1'b0;
        #20;
        chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        chk("rst_rti", 64'(jtag_state_rti), 64'd1);
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rst_ir_in", 64'(ir_in), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Loopback
        mode = 0;
        send(2'b01, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5, 165, 4);
        wait_done();
        #1 chk("idle_ir_in_held", 64'(ir_in), 64'd1);
        send(2'b11, 38'h15_0F0F_F0F0, 38'h15_0F0F_F0F0, 165, 4);
        wait_done();

        // Capture from slave model
        mode = 1;
        model_init = 38'h0_0000_0001;
        send(2'b01, 38'h3F_FFFF_FFFF, 38'h0_0000_0001, 165, 4);
        wait_done();
        model_init = 38'h25_1234_5678;
        send(2'b01, 38'h00_0000_0000, 38'h25_1234_5678, 165, 4);
        wait_done();

        // Backpressure with an ignored command in the hold window
        mode = 0;
        bus_if.rsp_ready = 1'b0;
        send(2'b01, 38'h0C_3333_CCCC, 38'h0C_3333_CCCC, 165, 4);
        wait_sig("bp_rsp_valid_timeout", 0);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_data  = 38'h3F_0000_FFFF;
        bp_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.cmd_ready) bp_bad++;
        end
        chk("bp_cmd_ready_low", 64'(bp_bad), 64'd0);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_cmd_ready_before_take", 64'(bus_if.cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_cmd_ready_after_take", 64'(bus_if.cmd_ready), 64'd1);
        chk("bp_rsp_valid_dropped", 64'(bus_if.rsp_valid), 64'd0);
        wait_done();

        // Reset in slot 10 of SHIFT
        send(2'b10, 38'h1F_AAAA_5555, 38'h1F_AAAA_5555, 165, 4);
        wait_sig("sdr_timeout", 1);
        repeat (40) @(posedge clk);
        #3 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_outputs",
            64'({bus_if.cmd_ready, jtag_state_rti, tck, tdi, bus_if.rsp_valid,
                 ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr}),
            64'(11'b11_000_00_0000));
        chk("mid_rst_rsp_data", 64'(bus_if.rsp_data), 64'd0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        rv_after = rsp_seen_cnt;
        repeat (200) @(negedge clk);
        chk("no_rsp_after_reset", 64'(rsp_seen_cnt - rv_after), 64'd0);

        // Repeated IR: UIR skipped only when the optional feature is built in
        send(2'b10, 38'h01_2345_6789, 38'h01_2345_6789, 165, 4);
`ifdef DEBUG_HOST_SKIP_IR_EN
        send(2'b10, 38'h3E_DCBA_9876, 38'h3E_DCBA_9876, 161, 0);
`else
        send(2'b10, 38'h3E_DCBA_9876, 38'h3E_DCBA_9876, 165, 4);
`endif
        send(2'b00, 38'h2B_ADBE_EF00, 38'h2B_ADBE_EF00, 165, 4);
        wait_done();

        repeat (5) @(posedge clk);
        chk("onehot_violations", 64'(onehot_bad), 64'd0);
        chk("tdi_setup_violations", 64'(tdi_bad), 64'd0);
        chk("rsp_hold_violations", 64'(hold_bad), 64'd0);
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
